// File: rtl/lfsr_rng_gen_pkg.sv
// Shared definitions for the LFSR random source.
// Contents:
//   draw_state_t  - draw FSM states (IDLE, STEP, CHECK)
//   DEFAULT_TAPS  - default feedback mask (bits 7,3,2,0)
//   DEFAULT_SEED  - default reset / lockup-recovery state
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    CHECK = 2'd2
  } draw_state_t;

  localparam logic [7:0] DEFAULT_TAPS = 8'h8D;
  localparam logic [7:0] DEFAULT_SEED = 8'h0F;

endpackage

// File: rtl/lfsr_rng_gen_if.sv
// Draw handshake between a consumer (spawn/position logic) and the generator.
// Signals:
//   req      consumer -> gen  draw request
//   limit    consumer -> gen  inclusive upper bound for the drawn value
//   busy     gen -> consumer  draw in progress
//   valid    gen -> consumer  one-cycle pulse, value/fallback valid
//   value    gen -> consumer  drawn number, held between pulses
//   fallback gen -> consumer  retries exhausted, value equals limit
interface lfsr_rng_gen_if #(
  parameter int OUT_W = 4
);

  logic             req;
  logic [OUT_W-1:0] limit;
  logic             busy;
  logic             valid;
  logic [OUT_W-1:0] value;
  logic             fallback;

  modport master (
    output req, limit,
    input  busy, valid, value, fallback
  );

  modport slave (
    input  req, limit,
    output busy, valid, value, fallback
  );

endinterface

// File: rtl/lfsr_rng_gen_core.sv
// Fibonacci LFSR state register.
// Ports:
//   clock     in  rising-edge clock
//   reset     in  synchronous, active-low; loads SEED
//   step      in  advance the register one position
//   load      in  load load_val (takes priority over step)
//   load_val  in  new state; zero is replaced by SEED so the register never locks up
//   state     out current LFSR state
module lfsr_core
  import rng_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic             feedback;

  assign feedback = ^(state_q & TAPS);
  assign state    = state_q;

  // A nonzero state can never shift into all-zeros through the feedback,
  // so guarding the load path is enough to keep the register out of lockup.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= SEED;
    end else if (load) begin
      state_q <= (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      state_q <= {state_q[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/lfsr_rng_gen.sv
// Random source for game logic: free-running LFSR plus range-limited draws.
// A draw advances the LFSR STEPS times, then accepts the low OUT_W bits if
// they are <= limit; otherwise it retries, up to MAX_TRIES attempts, after
// which it returns limit with fallback set.
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-low
//   enable     in   free-run one step per cycle while idle
//   seed_load  in   load seed_in (zero maps to SEED); aborts any draw
//   seed_in    in   new seed
//   state_out  out  current LFSR state
//   bus        slave side of the draw handshake (req/limit/busy/valid/value/fallback)
module lfsr_rng_gen
  import rng_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(DEFAULT_SEED),
  parameter int               OUT_W     = 4,
  parameter int               STEPS     = 1,
  parameter int               MAX_TRIES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state_out,
  lfsr_rng_gen_if.slave    bus
);

  localparam int STEP_W = $clog2(STEPS) + 1;
  localparam int TRY_W  = $clog2(MAX_TRIES) + 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
  localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_TRIES - 1);

  draw_state_t       state_q, state_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [TRY_W-1:0]  try_cnt_q, try_cnt_d;
  logic [OUT_W-1:0]  limit_q, limit_d;
  logic [OUT_W-1:0]  value_q, value_d;
  logic              fallback_q, fallback_d;
  logic              valid_q, valid_d;
  logic              lfsr_step;
  logic [WIDTH-1:0]  lfsr;
  logic [OUT_W-1:0]  cand;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clock    (clock),
    .reset    (reset),
    .step     (lfsr_step),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (lfsr)
  );

  assign cand         = lfsr[OUT_W-1:0];
  assign state_out    = lfsr;
  assign bus.busy     = (state_q != IDLE);
  assign bus.valid    = valid_q;
  assign bus.value    = value_q;
  assign bus.fallback = fallback_q;

  // Draw FSM next-state logic. seed_load wins over everything except reset and
  // drops the FSM back to IDLE without a result. Only IDLE honours enable, so a
  // draw always sees exactly STEPS advances per attempt.
  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    try_cnt_d  = try_cnt_q;
    limit_d    = limit_q;
    value_d    = value_q;
    fallback_d = fallback_q;
    valid_d    = 1'b0;
    lfsr_step  = 1'b0;

    if (seed_load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          lfsr_step = enable;
          if (bus.req) begin
            limit_d    = bus.limit;
            step_cnt_d = '0;
            try_cnt_d  = '0;
            state_d    = STEP;
          end
        end
        STEP: begin
          lfsr_step = 1'b1;
          if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = '0;
            state_d    = CHECK;
          end else begin
            step_cnt_d = step_cnt_q + 1'b1;
          end
        end
        CHECK: begin
          if (cand <= limit_q) begin
            value_d    = cand;
            fallback_d = 1'b0;
            valid_d    = 1'b1;
            state_d    = IDLE;
          end else if (try_cnt_q == TRY_LAST) begin
            value_d    = limit_q;
            fallback_d = 1'b1;
            valid_d    = 1'b1;
            state_d    = IDLE;
          end else begin
            try_cnt_d = try_cnt_q + 1'b1;
            state_d   = STEP;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      step_cnt_q <= '0;
      try_cnt_q  <= '0;
      limit_q    <= '0;
      value_q    <= '0;
      fallback_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      try_cnt_q  <= try_cnt_d;
      limit_q    <= limit_d;
      value_q    <= value_d;
      fallback_q <= fallback_d;
      valid_q    <= valid_d;
    end
  end

endmodule
